uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter WIDTH_WORD, default 8, data bits per frame.
REQ-002 SHALL have parameter CANT_BIT_STOP, default 2, stop bits per frame.
REQ-003 SHALL have port i_clock  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous reset, active-high.
REQ-005 SHALL have port i_rate  input  1  one-cycle tick at 16x baud, from baud generator.
REQ-006 SHALL have port i_tx_start  input  1  request to send i_data_in.
REQ-007 SHALL have port i_data_in  input  WIDTH_WORD  word to transmit.
REQ-008 SHALL have port o_bit_tx  output  1  serial line, registered, idle high.
REQ-009 SHALL have port o_tx_done  output  1  one-cycle pulse at end of frame.
REQ-010 SHALL have port o_tx_busy  output  1  high from accept until frame end.

Function
REQ-011 SHALL use one-hot states IDLE, START, DATA, STOP (plus PARITY when enabled).
REQ-012 IDLE: on any i_clock edge with i_tx_start=1, SHALL latch i_data_in, clear tick and bit counters, go to START, and assert o_tx_busy.
REQ-013 i_tx_start while o_tx_busy=1 SHALL be ignored; no queuing.
REQ-014 Counters SHALL advance only on i_rate=1; without i_rate all state SHALL hold.
REQ-015 Each bit SHALL last exactly 16 i_rate ticks; the tick counter wraps 15->0 at the bit boundary.
REQ-016 START SHALL drive o_bit_tx=0.
REQ-017 DATA SHALL send WIDTH_WORD bits MSB first (bit WIDTH_WORD-1 first), matching the receiver's fill order.
REQ-018 STOP SHALL drive o_bit_tx=1 for CANT_BIT_STOP*16 ticks.
REQ-019 On the final STOP tick, SHALL pulse o_tx_done for exactly one i_clock cycle, return to IDLE, and deassert o_tx_busy on that same edge.
REQ-020 i_tx_start high on the o_tx_done cycle SHALL be ignored; acceptance starts the following cycle in IDLE.
REQ-021 A frame SHALL be (1+WIDTH_WORD+CANT_BIT_STOP)*16 ticks long; 176 ticks at defaults.
REQ-022 Changes on i_data_in after acceptance SHALL NOT affect the frame in flight.
REQ-023 Illegal state encodings SHALL recover to IDLE with the line high.

Reset
REQ-024 With i_reset=1 on an edge, SHALL enter IDLE, clear counters and the shift register, and set o_bit_tx=1, o_tx_done=0, o_tx_busy=0.
REQ-025 Reset mid-frame SHALL abort the frame with no o_tx_done pulse; the line is high from the next edge.
REQ-026 Reset SHALL take priority over i_tx_start and i_rate.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: SHALL insert one PARITY bit (16 ticks) between DATA and STOP, with even parity over the data word; frame length grows by 16 ticks.
REQ-028 Macro undefined: SHALL contain no parity logic and follow DATA directly with STOP; this is the default, for compatibility with the existing receiver.

Structure
REQ-029 Shared package SHALL hold WIDTH_WORD and CANT_BIT_STOP defaults, TICKS_PER_BIT=16, and the state encodings, for use by both TX and RX.
REQ-030 SHALL be a single module with no sub-module; the baud tick comes from outside.

Verification
REQ-031 Send 0xA5 at defaults with i_rate every 4 clocks -> line 0 for 16 ticks; bits 1,0,1,0,0,1,0,1; 1 for 32 ticks; one o_tx_done pulse at tick 176.
REQ-032 Pulse i_tx_start with 0x3C at tick 50 of the 0xA5 frame -> 0xA5 frame unchanged; 0x3C not sent.
REQ-033 Hold i_tx_start=1 continuously with 0xFF then 0x00 -> back-to-back frames with one idle-high cycle between them; one done pulse per frame.
REQ-034 Assert i_reset at tick 90 -> o_bit_tx=1, o_tx_busy=0 next edge; no o_tx_done; a later 0x81 frame is correct.
REQ-035 With UART_TX_PARITY_EN, send 0xA5 -> parity bit 0 and a 192-tick frame; send 0x07 -> parity bit 1.
REQ-036 Loop uart_tx back to the receiver (parity off), 256 random words -> each o_data_out equals the sent word, one rx done per frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame defaults, bit timing and one-hot state codes for TX and RX.
package uart_tx_pkg;

  localparam int WIDTH_WORD_DEF    = 8;
  localparam int CANT_BIT_STOP_DEF = 2;
  localparam int TICKS_PER_BIT     = 16;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_STOP   = 5'b01000,
    ST_PARITY = 5'b10000
  } state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter, MSB first, 16 ticks per bit, registered line output.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int WIDTH_WORD    = WIDTH_WORD_DEF,
  parameter int CANT_BIT_STOP = CANT_BIT_STOP_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rate,
  input  logic                  i_tx_start,
  input  logic [WIDTH_WORD-1:0] i_data_in,
  output logic                  o_bit_tx,
  output logic                  o_tx_done,
  output logic                  o_tx_busy
);

  localparam int BCW = $clog2(WIDTH_WORD + CANT_BIT_STOP + 1);

  state_t                state_q;
  logic [3:0]            tick_q;
  logic [BCW-1:0]        bit_q;
  logic [WIDTH_WORD-1:0] shreg_q;
  logic                  bit_tx_q;
  logic                  done_q;
  logic                  busy_q;
`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`endif

  logic last_tick;
  assign last_tick = i_rate && (tick_q == 4'(TICKS_PER_BIT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      bit_tx_q <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          bit_tx_q <= 1'b1;
          if (i_tx_start) begin
            state_q  <= ST_START;
            shreg_q  <= i_data_in;
            tick_q   <= '0;
            bit_q    <= '0;
            bit_tx_q <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= ^i_data_in;
`endif
          end
        end
        ST_START: if (i_rate) begin
          tick_q <= tick_q + 4'd1;
          if (last_tick) begin
            state_q  <= ST_DATA;
            bit_q    <= '0;
            bit_tx_q <= shreg_q[WIDTH_WORD-1];
            shreg_q  <= shreg_q << 1;
          end
        end
        ST_DATA: if (i_rate) begin
          tick_q <= tick_q + 4'd1;
          if (last_tick) begin
            if (bit_q == BCW'(WIDTH_WORD - 1)) begin
              bit_q    <= '0;
`ifdef UART_TX_PARITY_EN
              state_q  <= ST_PARITY;
              bit_tx_q <= par_q;
`else
              state_q  <= ST_STOP;
              bit_tx_q <= 1'b1;
`endif
            end else begin
              bit_q    <= bit_q + BCW'(1);
              bit_tx_q <= shreg_q[WIDTH_WORD-1];
              shreg_q  <= shreg_q << 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (i_rate) begin
          tick_q <= tick_q + 4'd1;
          if (last_tick) begin
            state_q  <= ST_STOP;
            bit_q    <= '0;
            bit_tx_q <= 1'b1;
          end
        end
`endif
        ST_STOP: if (i_rate) begin
          tick_q   <= tick_q + 4'd1;
          bit_tx_q <= 1'b1;
          if (last_tick) begin
            if (bit_q == BCW'(CANT_BIT_STOP - 1)) begin
              state_q <= ST_IDLE;
              bit_q   <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + BCW'(1);
            end
          end
        end
        // Any corrupted encoding falls back to an idle, high line.
        default: begin
          state_q  <= ST_IDLE;
          tick_q   <= '0;
          bit_q    <= '0;
          bit_tx_q <= 1'b1;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_bit_tx  = bit_tx_q;
  assign o_tx_done = done_q;
  assign o_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, ignored starts, back-to-back, mid-frame reset.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rate = 1'b0;
  logic       i_tx_start = 1'b0;
  logic [7:0] i_data_in = 8'h00;
  logic       o_bit_tx, o_tx_done, o_tx_busy;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic line_n1, busy_n1, done_n1;

  uart_tx dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rate(i_rate),
    .i_tx_start(i_tx_start), .i_data_in(i_data_in),
    .o_bit_tx(o_bit_tx), .o_tx_done(o_tx_done), .o_tx_busy(o_tx_busy)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) if (o_tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One baud tick: i_rate high for one clock, then three quiet clocks.
  task automatic tick();
    i_rate = 1'b1;
    @(negedge i_clock);
    line_n1 = o_bit_tx; busy_n1 = o_tx_busy; done_n1 = o_tx_done;
    i_rate = 1'b0;
    repeat (3) @(negedge i_clock);
  endtask

  // Line level after k ticks of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int k, input bit par);
    int idx;
    idx = k / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[8 - idx];
    if (par && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit accepted, input bit hold,
                           input logic [7:0] nxt, input int inj_at, input int rst_at);
    int nt, dc0;
    nt  = (1 + 8 + 2 + int'(PAR)) * 16;
    dc0 = done_cnt;
    if (!accepted) begin
      i_data_in  = d;
      i_tx_start = 1'b1;
      @(negedge i_clock);
    end
    i_tx_start = hold;
    i_data_in  = nxt;
    chk("accept_busy", o_tx_busy, 1);
    chk("start_low", o_bit_tx, 0);
    for (int k = 1; k <= nt; k++) begin
      if (k == inj_at) begin i_tx_start = 1'b1; i_data_in = 8'h3C; end
      if (k == rst_at) i_reset = 1'b1;
      tick();
      if (k == inj_at) begin i_tx_start = 1'b0; i_data_in = nxt; end
      if (k == rst_at) begin
        i_reset = 1'b0;
        chk("rst_line", line_n1, 1);
        chk("rst_busy", busy_n1, 0);
        chk("rst_no_done", done_cnt - dc0, 0);
        return;
      end
      chk($sformatf("done_k%0d", k), done_n1, (k == nt));
      if (k < nt) begin
        chk($sformatf("line_%02h_k%0d", d, k), o_bit_tx, exp_bit(d, k, PAR));
        chk($sformatf("busy_k%0d", k), o_tx_busy, 1);
      end else begin
        chk("end_busy_low", busy_n1, 0);
        chk("end_line_high", line_n1, 1);
      end
    end
    chk("one_done", done_cnt - dc0, 1);
  endtask

  initial begin
    repeat (3) @(negedge i_clock);
    chk("rst_line0", o_bit_tx, 1);
    chk("rst_busy0", o_tx_busy, 0);
    chk("rst_done0", o_tx_done, 0);
    i_reset = 1'b0;
    @(negedge i_clock);

    // Input data changes after acceptance must not leak into the frame.
    run_frame(8'hA5, 1'b0, 1'b0, 8'h5A, 0, 0);

    // Start pulse mid-frame is dropped, nothing queued afterwards.
    run_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 50, 0);
    tick();
    chk("no_queue_busy", o_tx_busy, 0);
    chk("no_queue_line", o_bit_tx, 1);

    // Start held high: second frame begins one cycle after done.
    run_frame(8'hFF, 1'b0, 1'b1, 8'h00, 0, 0);
    run_frame(8'h00, 1'b1, 1'b0, 8'h00, 0, 0);

    // Reset at tick 90 aborts; the next frame is clean.
    run_frame(8'h5A, 1'b0, 1'b0, 8'h5A, 0, 90);
    @(negedge i_clock);
    chk("post_rst_busy", o_tx_busy, 0);
    run_frame(8'h81, 1'b0, 1'b0, 8'h81, 0, 0);

    // Odd-weight word: parity bit is 1 when parity is enabled.
    run_frame(8'h07, 1'b0, 1'b0, 8'h07, 0, 0);

    for (int r = 0; r < 3; r++) begin
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      run_frame(w, 1'b0, 1'b0, ~w, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
